// File: rtl/aes_pkg.sv
// Shared AES MixColumns types, GF(2^8) constant multipliers and engine FSM encoding.
// Latency: none, combinational helpers only.
// Backpressure: not applicable, no handshaked ports.
package aes_pkg;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [31:0]  aes_col_t;
    typedef logic [127:0] aes_state_t;

    // x^8 folded back by the AES field polynomial 0x11B
    localparam aes_byte_t AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_e;

    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic aes_byte_t gf_mul2(input aes_byte_t b);
        return xtime(b);
    endfunction

    function automatic aes_byte_t gf_mul3(input aes_byte_t b);
        return xtime(b) ^ b;
    endfunction

    function automatic aes_byte_t gf_mul9(input aes_byte_t b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic aes_byte_t gf_mulb(input aes_byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic aes_byte_t gf_muld(input aes_byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic aes_byte_t gf_mule(input aes_byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// One-column AES MixColumns / InvMixColumns transform (32-bit, row 0 in the MSB byte).
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
// Ports: col_in (column), inverse (1 = InvMixColumns), col_out (transformed column).
// Build option: MIXCOL_INV_EN builds the inverse datapath; without it inverse is ignored.
module mix_single_column
    import aes_pkg::*;
(
    input  aes_col_t col_in,
    input  logic     inverse,
    output aes_col_t col_out
);

    aes_byte_t a   [4];
    aes_byte_t fwd [4];

    assign a[0] = col_in[31:24];
    assign a[1] = col_in[23:16];
    assign a[2] = col_in[15:8];
    assign a[3] = col_in[7:0];

    // Each output row uses the 02 03 01 01 row rotated right by the row number
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fwd[i] = gf_mul2(a[i]) ^ gf_mul3(a[(i + 1) % 4]) ^ a[(i + 2) % 4] ^ a[(i + 3) % 4];
        end
    end

`ifdef MIXCOL_INV_EN
    aes_byte_t inv [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            inv[i] = gf_mule(a[i]) ^ gf_mulb(a[(i + 1) % 4]) ^ gf_muld(a[(i + 2) % 4]) ^ gf_mul9(a[(i + 3) % 4]);
        end
    end

    assign col_out = inverse ? {inv[0], inv[1], inv[2], inv[3]}
                             : {fwd[0], fwd[1], fwd[2], fwd[3]};
`else
    // Forward-only build: the select is kept on the port list but has no effect
    logic unused_inverse;
    assign unused_inverse = inverse;
    assign col_out        = {fwd[0], fwd[1], fwd[2], fwd[3]};
`endif

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative handshaked AES (Inv)MixColumns over a 128-bit state, COLS_PER_CYCLE columns per BUSY cycle.
// Latency: 4/COLS_PER_CYCLE cycles from accept edge to OutValid; DONE->BUSY reload with no bubble.
// Backpressure: result held in DONE until OutReady; InReady only in IDLE or in DONE with OutReady.
// Ports: Clk/Rst (sync, active-high); InValid/InReady/InData/Inverse in; OutValid/OutReady/OutData out; Busy.
// Build option: MIXCOL_INV_EN enables InvMixColumns selected per block by Inverse.
module mix_columns_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         InValid,
    output logic         InReady,
    input  logic [127:0] InData,
    input  logic         Inverse,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [127:0] OutData,
    output logic         Busy
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
            $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Counter value of the group holding column 3, and the per-cycle step
    localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

    mc_state_e  st_q, st_nxt;
    logic [1:0] cnt_q;
    aes_state_t data_q;
    logic       mode_q;
    logic       accept;

    aes_col_t   cols     [4];
    aes_col_t   cols_nxt [4];
    aes_col_t   grp_in   [COLS_PER_CYCLE];
    aes_col_t   grp_out  [COLS_PER_CYCLE];
    logic [1:0] grp_idx  [COLS_PER_CYCLE];
    aes_state_t data_busy;

    // Datapath: transform the addressed column group in place
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            cols[c] = data_q[127 - 32*c -: 32];
        end
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            grp_idx[g] = cnt_q + 2'(g);
            grp_in[g]  = cols[grp_idx[g]];
        end
    end

    generate
        for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
            mix_single_column u_col (
                .col_in  (grp_in[g]),
                .inverse (mode_q),
                .col_out (grp_out[g])
            );
        end
    endgenerate

    always_comb begin
        cols_nxt = cols;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            cols_nxt[grp_idx[g]] = grp_out[g];
        end
        data_busy = {cols_nxt[0], cols_nxt[1], cols_nxt[2], cols_nxt[3]};
    end

    assign accept = InValid && InReady;

    // State register and datapath registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            st_q   <= IDLE;
            cnt_q  <= 2'd0;
            data_q <= '0;
            mode_q <= 1'b0;
        end else begin
            st_q <= st_nxt;
            if (accept) begin
                data_q <= InData;
                mode_q <= Inverse;
                cnt_q  <= 2'd0;
            end else if (st_q == BUSY) begin
                data_q <= data_busy;
                cnt_q  <= cnt_q + CNT_STEP;
            end
        end
    end

    // Next-state logic
    always_comb begin
        st_nxt = st_q;
        case (st_q)
            IDLE:    if (InValid) st_nxt = BUSY;
            BUSY:    if (cnt_q == LAST_CNT) st_nxt = DONE;
            DONE:    if (OutReady) st_nxt = InValid ? BUSY : IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    // Outputs are forced quiet for the whole time Rst is high
    always_comb begin
        InReady  = 1'b0;
        OutValid = 1'b0;
        Busy     = 1'b0;
        OutData  = '0;
        if (!Rst) begin
            InReady  = (st_q == IDLE) || ((st_q == DONE) && OutReady);
            OutValid = (st_q == DONE);
            Busy     = (st_q == BUSY);
            OutData  = data_q;
        end
    end

endmodule
